amba_axi4_burst_monitor: RTL

Synthesizable AXI4 transaction monitor that taps all five channels of one manager–subordinate link. Unlike the per-channel handshake checkers, it tracks burst-level state: outstanding transactions per ID, W-beat counts against AWLEN, and RLAST position against ARLEN. It also applies handshake-stability and MAXWAIT timeout rules. Violations are reported as sticky error bits plus a first-error code, so the monitor works in silicon and in simulation, and formal benches can assert `err == 0`.

---
 rtl/amba_axi4_pkg.sv | 33 +++
 rtl/amba_axi4_len_fifo.sv | 53 +++++
 rtl/amba_axi4_burst_monitor.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amba_axi4_pkg.sv
// Shared types for the AXI4 burst monitor: error-bit indices, the "no error" code
// and the 8-bit burst length type.
package amba_axi4_pkg;

  localparam int ERR_BITS = 10;

  typedef logic [7:0] axi4_len_t;

  typedef enum logic [3:0] {
    ERR_AW_UNSTABLE          = 4'd0,
    ERR_W_UNSTABLE           = 4'd1,
    ERR_AR_UNSTABLE          = 4'd2,
    ERR_WLAST_MISMATCH       = 4'd3,
    ERR_W_LEAD_OVERFLOW      = 4'd4,
    ERR_B_ORPHAN             = 4'd5,
    ERR_R_ORPHAN             = 4'd6,
    ERR_RLAST_MISMATCH       = 4'd7,
    ERR_OUTSTANDING_OVERFLOW = 4'd8,
    ERR_TIMEOUT              = 4'd9,
    ERR_NONE                 = 4'hF
  } axi4_err_e;

  // Lowest set index wins so simultaneous errors report deterministically.
  function automatic axi4_err_e first_err(input logic [ERR_BITS-1:0] vec);
    axi4_err_e idx;
    idx = ERR_NONE;
    for (int i = ERR_BITS - 1; i >= 0; i--) begin
      if (vec[i]) idx = axi4_err_e'(i[3:0]);
    end
    return idx;
  endfunction

endpackage

// File: rtl/amba_axi4_len_fifo.sv
// Small synchronous FIFO holding burst descriptors; pushes while full and pops
// while empty are ignored so the caller can flag them without corrupting state.
module amba_axi4_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/amba_axi4_burst_monitor.sv
// AXI4 burst-level monitor: tracks outstanding bursts per ID, W/R beat counts,
// handshake stability and stall timeouts, reporting sticky errors plus a first-error code.
module amba_axi4_burst_monitor
  import amba_axi4_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAXWAIT         = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     AWVALID,
  input  logic                     AWREADY,
  input  logic [ID_WIDTH-1:0]      AWID,
  input  logic [ADDRESS_WIDTH-1:0] AWADDR,
  input  axi4_len_t                AWLEN,
  input  logic                     WVALID,
  input  logic                     WREADY,
  input  logic                     WLAST,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ID_WIDTH-1:0]      BID,
  input  logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [ID_WIDTH-1:0]      ARID,
  input  logic [ADDRESS_WIDTH-1:0] ARADDR,
  input  axi4_len_t                ARLEN,
  input  logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     RLAST,
  input  logic [ID_WIDTH-1:0]      RID,
  input  logic                     err_clear,
  output logic [ERR_BITS-1:0]      err,
  output logic [3:0]               err_first,
  output logic [$clog2(MAX_OUTSTANDING*(2**ID_WIDTH)):0] wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING*(2**ID_WIDTH)):0] rd_outstanding
);

  localparam int NID = 2**ID_WIDTH;
  localparam int OCW = $clog2(MAX_OUTSTANDING * NID) + 1;
  localparam int FCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WW  = $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAXWAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAXWAIT - 1);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  logic                              aw_stall_q, w_stall_q, ar_stall_q;
  logic [ID_WIDTH+ADDRESS_WIDTH+7:0] aw_pay_q, ar_pay_q;
  logic [DATA_WIDTH:0]               w_pay_q;
  logic                              e_aw_unst, e_w_unst, e_ar_unst;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_stall_q <= 1'b0;
      w_stall_q  <= 1'b0;
      ar_stall_q <= 1'b0;
      aw_pay_q   <= '0;
      ar_pay_q   <= '0;
      w_pay_q    <= '0;
    end else begin
      aw_stall_q <= AWVALID && !AWREADY;
      w_stall_q  <= WVALID && !WREADY;
      ar_stall_q <= ARVALID && !ARREADY;
      aw_pay_q   <= {AWID, AWADDR, AWLEN};
      ar_pay_q   <= {ARID, ARADDR, ARLEN};
      w_pay_q    <= {WLAST, WDATA};
    end
  end

  assign e_aw_unst = aw_stall_q && (!AWVALID || ({AWID, AWADDR, AWLEN} != aw_pay_q));
  assign e_w_unst  = w_stall_q  && (!WVALID  || ({WLAST, WDATA} != w_pay_q));
  assign e_ar_unst = ar_stall_q && (!ARVALID || ({ARID, ARADDR, ARLEN} != ar_pay_q));

  // Per-channel stall counters saturate so the timeout fires exactly once per stall.
  logic [4:0]    ch_stall;
  logic [WW-1:0] wait_q [5];
  logic          e_timeout;

  assign ch_stall = {RVALID && !RREADY, BVALID && !BREADY, ARVALID && !ARREADY,
                     WVALID && !WREADY, AWVALID && !AWREADY};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 5; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!ch_stall[i])             wait_q[i] <= '0;
        else if (wait_q[i] != WAIT_MAX) wait_q[i] <= wait_q[i] + WW'(1);
      end
    end
  end

  always_comb begin
    e_timeout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ch_stall[i] && (wait_q[i] == WAIT_LAST)) e_timeout = 1'b1;
    end
  end

  logic                aw_push, aw_pop, aw_full, aw_empty;
  logic [ID_WIDTH+7:0] aw_head;
  logic [FCW-1:0]      aw_count;

  amba_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ID_WIDTH + 8)) u_aw_fifo (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .push_i (aw_push),
    .pop_i  (aw_pop),
    .data_i ({AWID, AWLEN}),
    .data_o (aw_head),
    .full_o (aw_full),
    .empty_o(aw_empty),
    .count_o(aw_count)
  );

  logic [8:0]          wbeat_q, wbeat_d, w_beats;
  logic                lead_valid_q, lead_valid_d;
  logic [8:0]          lead_cnt_q, lead_cnt_d;
  logic                bp_inc, bypass;
  logic [ID_WIDTH-1:0] bp_inc_id;
  logic                e_wlast, e_lead, e_aw_ovf;

  assign w_beats = wbeat_q + 9'd1;
  // AW and its only WLAST in the same cycle with nothing queued: match them directly.
  assign bypass  = aw_hs && !lead_valid_q && w_hs && WLAST && aw_empty;

  always_comb begin
    aw_push      = 1'b0;
    aw_pop       = 1'b0;
    wbeat_d      = wbeat_q;
    lead_valid_d = lead_valid_q;
    lead_cnt_d   = lead_cnt_q;
    bp_inc       = 1'b0;
    bp_inc_id    = '0;
    e_wlast      = 1'b0;
    e_lead       = 1'b0;
    e_aw_ovf     = 1'b0;
    if (aw_hs) begin
      if (lead_valid_q) begin
        e_wlast      = (lead_cnt_q != ({1'b0, AWLEN} + 9'd1));
        bp_inc       = 1'b1;
        bp_inc_id    = AWID;
        lead_valid_d = 1'b0;
      end else if (bypass) begin
        e_wlast   = (w_beats != ({1'b0, AWLEN} + 9'd1));
        bp_inc    = 1'b1;
        bp_inc_id = AWID;
      end else if (aw_full) begin
        e_aw_ovf = 1'b1;
      end else begin
        aw_push = 1'b1;
      end
    end
    if (w_hs) begin
      wbeat_d = WLAST ? 9'd0 : w_beats;
      if (WLAST && !aw_empty) begin
        aw_pop    = 1'b1;
        e_wlast   = e_wlast || (w_beats != ({1'b0, aw_head[7:0]} + 9'd1));
        bp_inc    = 1'b1;
        bp_inc_id = aw_head[ID_WIDTH+7:8];
      end else if (WLAST && !bypass) begin
        if (lead_valid_d) begin
          e_lead = 1'b1;
        end else begin
          lead_valid_d = 1'b1;
          lead_cnt_d   = w_beats;
        end
      end
    end
  end

  logic [OCW-1:0] bpend_q [NID];
  logic [OCW-1:0] bpend_d [NID];
  logic           e_borph;

  always_comb begin
    bpend_d = bpend_q;
    e_borph = 1'b0;
    if (bp_inc) bpend_d[bp_inc_id] = bpend_d[bp_inc_id] + OCW'(1);
    if (b_hs) begin
      if (bpend_q[BID] == '0) e_borph = 1'b1;
      else                    bpend_d[BID] = bpend_d[BID] - OCW'(1);
    end
  end

  logic [NID-1:0] r_push, r_pop, r_full, r_empty;
  axi4_len_t      r_head  [NID];
  logic [FCW-1:0] r_count [NID];

  for (genvar g = 0; g < NID; g++) begin : g_rfifo
    amba_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(8)) u_r_fifo (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .push_i (r_push[g]),
      .pop_i  (r_pop[g]),
      .data_i (ARLEN),
      .data_o (r_head[g]),
      .full_o (r_full[g]),
      .empty_o(r_empty[g]),
      .count_o(r_count[g])
    );
  end

  logic [8:0] rbeat_q [NID];
  logic [8:0] rbeat_d [NID];
  logic [8:0] r_beats, r_target;
  logic       e_rorph, e_rlast, e_ar_ovf;

  assign r_beats  = rbeat_q[RID] + 9'd1;
  assign r_target = {1'b0, r_head[RID]} + 9'd1;

  always_comb begin
    r_push   = '0;
    r_pop    = '0;
    rbeat_d  = rbeat_q;
    e_rorph  = 1'b0;
    e_rlast  = 1'b0;
    e_ar_ovf = 1'b0;
    if (ar_hs) begin
      if (r_full[ARID]) e_ar_ovf = 1'b1;
      else              r_push[ARID] = 1'b1;
    end
    if (r_hs) begin
      if (r_empty[RID]) begin
        e_rorph = 1'b1;
      end else if (RLAST || (r_beats == r_target)) begin
        e_rlast      = !(RLAST && (r_beats == r_target));
        r_pop[RID]   = 1'b1;
        rbeat_d[RID] = 9'd0;
      end else begin
        rbeat_d[RID] = r_beats;
      end
    end
  end

  logic [ERR_BITS-1:0] new_err, err_q, err_d;
  axi4_err_e           err_first_q, err_first_d;

  assign new_err = {e_timeout, e_aw_ovf || e_ar_ovf, e_rlast, e_rorph, e_borph,
                    e_lead, e_wlast, e_ar_unst, e_w_unst, e_aw_unst};

  always_comb begin
    err_d       = err_q | new_err;
    err_first_d = err_first_q;
    if (err_clear) begin
      err_d       = '0;
      err_first_d = ERR_NONE;
    end else if ((err_q == '0) && (new_err != '0)) begin
      err_first_d = first_err(new_err);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wbeat_q      <= '0;
      lead_valid_q <= 1'b0;
      lead_cnt_q   <= '0;
      for (int i = 0; i < NID; i++) begin
        bpend_q[i] <= '0;
        rbeat_q[i] <= '0;
      end
      err_q       <= '0;
      err_first_q <= ERR_NONE;
    end else begin
      wbeat_q      <= wbeat_d;
      lead_valid_q <= lead_valid_d;
      lead_cnt_q   <= lead_cnt_d;
      bpend_q      <= bpend_d;
      rbeat_q      <= rbeat_d;
      err_q        <= err_d;
      err_first_q  <= err_first_d;
    end
  end

  always_comb begin
    wr_outstanding = OCW'(aw_count);
    rd_outstanding = '0;
    for (int i = 0; i < NID; i++) begin
      wr_outstanding = wr_outstanding + bpend_q[i];
      rd_outstanding = rd_outstanding + OCW'(r_count[i]);
    end
  end

  assign err       = err_q;
  assign err_first = err_first_q;

endmodule
